// File: rtl/dmux8way16_buf_pkg.sv
// ----------------------------------------------------------------------------
// dmux_pkg : shared sizing and select-decode helper for the 8-way word demux
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dmux_pkg;

   localparam int WIDTH = 16;
   localparam int NWAY  = 8;
   localparam int SELW  = 3;

   function automatic logic [NWAY-1:0] sel_onehot(input logic [SELW-1:0] sel);
      logic [NWAY-1:0] vec;
      vec      = '0;
      vec[sel] = 1'b1;
      return vec;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dmux8way16_buf_if.sv
// ----------------------------------------------------------------------------
// dmux8way16_buf_if : input handshake, per-channel outputs and pointer view
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface dmux8way16_buf_if;
   import dmux_pkg::*;

   logic                  in_valid;
   logic                  in_ready;
   logic [WIDTH-1:0]      in_data;
   logic [SELW-1:0]       in_sel;
   logic                  in_mode;
   logic [NWAY-1:0]       out_valid;
   logic [NWAY-1:0]       out_ready;
   logic [NWAY*WIDTH-1:0] out_data;
   logic [SELW-1:0]       scat_ptr;

   modport slave (
      input  in_valid, in_data, in_sel, in_mode, out_ready,
      output in_ready, out_valid, out_data, scat_ptr
   );

   modport master (
      output in_valid, in_data, in_sel, in_mode, out_ready,
      input  in_ready, out_valid, out_data, scat_ptr
   );

endinterface

`default_nettype wire

// File: rtl/dmux8way16_buf_slot.sv
// ----------------------------------------------------------------------------
// dmux_slot : one-entry holding register with valid/ready on the output side
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dmux_slot
   import dmux_pkg::*;
(
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             load,
   input  wire logic [WIDTH-1:0] data_in,
   input  wire logic             out_ready,
   output logic                  out_valid,
   output logic [WIDTH-1:0]      out_data
);

   // Load wins over drain so a same-cycle drain+reload keeps valid high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= data_in;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/dmux8way16_buf.sv
// ----------------------------------------------------------------------------
// dmux8way16_buf : buffered 1-to-8 demux of 16-bit words, addressed or scatter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dmux8way16_buf
   import dmux_pkg::*;
(
   input  wire logic        clk,
   input  wire logic        rst_n,
   dmux8way16_buf_if.slave  bus
);

   logic [SELW-1:0]       dst;
   logic [SELW-1:0]       ptr;
   logic                  ready;
   logic                  accept;
   logic [NWAY-1:0]       load_vec;
   logic [NWAY-1:0]       slot_valid;
   logic [NWAY*WIDTH-1:0] slot_data;

   assign dst      = bus.in_mode ? ptr : bus.in_sel;
   assign ready    = !slot_valid[dst] || bus.out_ready[dst];
   assign accept   = bus.in_valid && ready;
   assign load_vec = accept ? sel_onehot(dst) : '0;

   generate
      for (genvar i = 0; i < NWAY; i++) begin : g_slot
         dmux_slot u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load_vec[i]),
            .data_in   (bus.in_data),
            .out_ready (bus.out_ready[i]),
            .out_valid (slot_valid[i]),
            .out_data  (slot_data[i*WIDTH +: WIDTH])
         );
      end
   endgenerate

   // Pointer only moves on scatter-mode accepts; natural SELW overflow wraps it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (accept && bus.in_mode) begin
         ptr <= ptr + 1'b1;
      end
   end

   assign bus.in_ready  = ready;
   assign bus.out_valid = slot_valid;
   assign bus.out_data  = slot_data;
   assign bus.scat_ptr  = ptr;

endmodule

`default_nettype wire
